// File: rtl/bp_stream_to_lite_buffered.sv
// bp_stream_to_lite_buffered
//   Collects a memory stream (one header + N data beats of in_data_width_p
//   bits) into a single lite message carrying out_data_width_p bits of
//   payload. Completed messages are queued in a buffer_els_p-deep FIFO so the
//   master can stream the next message while the client stalls. Beats are
//   placed critical-word-first, wrapping inside the size-aligned window.
//   Payloads narrower than one beat are replicated across the output word.
//
//   Header layout (hdr_width_p bits):
//     [paddr_width_p-1:0]                 address
//     [paddr_width_p+2:paddr_width_p]     size (message is 2^size bytes)
//     [paddr_width_p+6:paddr_width_p+3]   msg_type (payload_mask_p bit index)
//     [hdr_width_p-1:paddr_width_p+7]     opaque, carried through unchanged
//
//   Optional feature macro: BP_STREAM_TO_LITE_LAST_CHECK_EN
//     Defined: each accepted beat's mem_last_i is compared with the beat
//     counter; a mismatch sets the sticky err_o. Undefined: err_o is 0.
//
//   Ports
//     clk_i            clock
//     reset_i          synchronous active-high reset
//     mem_header_i     stream header, held for every beat of a message
//     mem_data_i       stream beat data
//     mem_v_i          beat valid
//     mem_ready_and_o  beat accepted when mem_v_i & mem_ready_and_o
//     mem_last_i       master's final-beat marker (checked only with macro)
//     mem_o            {header, data} lite message at the FIFO head
//     mem_v_o          message valid
//     mem_ready_and_i  client ready; dequeue on mem_v_o & mem_ready_and_i
//     err_o            sticky last-beat mismatch flag
module bp_stream_to_lite_buffered #(
   parameter int          paddr_width_p    = 40,
   parameter int          hdr_width_p      = 64,
   parameter int          in_data_width_p  = 64,
   parameter int          out_data_width_p = 512,
   parameter logic [15:0] payload_mask_p   = '0,
   parameter int          buffer_els_p     = 2
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [hdr_width_p-1:0]                mem_header_i,
   input  logic [in_data_width_p-1:0]            mem_data_i,
   input  logic                                  mem_v_i,
   output logic                                  mem_ready_and_o,
   input  logic                                  mem_last_i,
   output logic [hdr_width_p+out_data_width_p-1:0] mem_o,
   output logic                                  mem_v_o,
   input  logic                                  mem_ready_and_i,
   output logic                                  err_o
);

   localparam int in_bytes_lp     = in_data_width_p / 8;
   localparam int lg_in_bytes_lp  = $clog2(in_bytes_lp);
   localparam int lg_in_dw_lp     = $clog2(in_data_width_p);
   localparam int out_bytes_lp    = out_data_width_p / 8;
   localparam int lg_ratio_lp     = $clog2(out_data_width_p / in_data_width_p);
   localparam int msg_width_lp    = hdr_width_p + out_data_width_p;
   localparam int ptr_w_lp        = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;
   localparam int cnt_w_lp        = $clog2(buffer_els_p + 1);
   localparam int size_lsb_lp     = paddr_width_p;
   localparam int type_lsb_lp     = paddr_width_p + 3;

   typedef enum logic [0:0] {e_idle, e_stream} state_e;

   state_e                     state_q;
   logic [hdr_width_p-1:0]     hdr_q;
   logic [lg_ratio_lp-1:0]     nbm1_q;
   logic [lg_ratio_lp-1:0]     cnt_q;
   logic                       ready_en_q;
   logic [out_data_width_p-1:0] asm_q;
   logic [out_data_width_p-1:0] asm_d;

   logic [msg_width_lp-1:0]    fifo_mem [buffer_els_p];
   logic [ptr_w_lp-1:0]        wr_ptr_q, rd_ptr_q;
   logic [cnt_w_lp-1:0]        count_q;

   logic [hdr_width_p-1:0]     cur_hdr;
   logic [2:0]                 live_size, cur_size;
   logic                       live_payload, cur_payload;
   logic [lg_ratio_lp-1:0]     live_nbm1, cur_nbm1, idx, slot;
   logic [lg_in_bytes_lp-1:0]  rep_mask;
   logic [out_data_width_p-1:0] rep_data, enq_data;
   logic                       final_beat, replicate, accept, enq, deq;

   // Header fields: the live header is used on the first beat, the latched
   // copy for the remaining beats of the message.
   assign cur_hdr      = (state_q == e_idle) ? mem_header_i : hdr_q;
   assign live_size    = mem_header_i[size_lsb_lp +: 3];
   assign live_payload = payload_mask_p[mem_header_i[type_lsb_lp +: 4]];
   assign cur_size     = cur_hdr[size_lsb_lp +: 3];
   assign cur_payload  = payload_mask_p[cur_hdr[type_lsb_lp +: 4]];

   // nb-1 = 2^(size-lg_in_bytes)-1, saturating at the full output word;
   // 0 for sub-beat sizes and non-payload messages.
   always_comb begin
      live_nbm1 = '0;
      for (int k = 0; k < lg_ratio_lp; k++)
         live_nbm1[k] = live_payload && (int'(live_size) > lg_in_bytes_lp + k);
      rep_mask = '0;
      for (int k = 0; k < lg_in_bytes_lp; k++)
         rep_mask[k] = (int'(cur_size) > k);
   end

   assign cur_nbm1   = (state_q == e_idle) ? live_nbm1 : nbm1_q;
   assign idx        = cur_hdr[lg_in_bytes_lp +: lg_ratio_lp];
   // Aligned window base plus wrapped offset from the critical word.
   assign slot       = (idx & ~cur_nbm1) | ((idx + cnt_q) & cur_nbm1);
   assign final_beat = (cnt_q == cur_nbm1);
   assign replicate  = cur_payload && (int'(cur_size) < lg_in_bytes_lp);

   // Only the final beat needs FIFO space; the registered count is used so a
   // same-cycle dequeue does not open space for this cycle's final beat.
   assign mem_ready_and_o = ready_en_q &
                            (~final_beat | (count_q < cnt_w_lp'(buffer_els_p)));
   assign accept = mem_v_i & mem_ready_and_o;
   assign enq    = accept & final_beat;
   assign deq    = mem_v_o & mem_ready_and_i;

   // Byte gi of the output takes beat byte (gi mod 2^size).
   genvar gi;
   generate
      for (gi = 0; gi < out_bytes_lp; gi++) begin : g_rep
         localparam logic [lg_in_bytes_lp-1:0] lo_lp = lg_in_bytes_lp'(gi % in_bytes_lp);
         logic [lg_in_bytes_lp-1:0] sel;
         assign sel = lo_lp & rep_mask;
         assign rep_data[8*gi +: 8] = mem_data_i[{sel, 3'b000} +: 8];
      end
   endgenerate

   always_comb begin
      asm_d = asm_q;
      if (replicate)
         asm_d = rep_data;
      else
         asm_d[{slot, lg_in_dw_lp'(0)} +: in_data_width_p] = mem_data_i;
   end

   // The final beat is folded in combinationally so the message can be
   // enqueued on the same edge the beat is accepted.
   assign enq_data = cur_payload ? asm_d : '0;

   // Assembly register is intentionally never cleared.
   always_ff @(posedge clk_i) begin
      if (accept && cur_payload)
         asm_q <= asm_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= e_idle;
         hdr_q      <= '0;
         nbm1_q     <= '0;
         cnt_q      <= '0;
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         if (accept) begin
            case (state_q)
               e_idle: begin
                  hdr_q  <= mem_header_i;
                  nbm1_q <= live_nbm1;
                  if (!final_beat) begin
                     state_q <= e_stream;
                     cnt_q   <= lg_ratio_lp'(1);
                  end
               end
               default: begin
                  if (final_beat) begin
                     state_q <= e_idle;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(buffer_els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (enq)
         fifo_mem[wr_ptr_q] <= {cur_hdr, enq_data};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (deq) rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({enq, deq})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign mem_v_o = (count_q != '0);
   assign mem_o   = fifo_mem[rd_ptr_q];

`ifdef BP_STREAM_TO_LITE_LAST_CHECK_EN
   logic err_q;
   always_ff @(posedge clk_i) begin
      if (reset_i)
         err_q <= 1'b0;
      else if (accept && (mem_last_i != final_beat))
         err_q <= 1'b1;
   end
   assign err_o = err_q;
`else
   logic unused_last;
   assign unused_last = mem_last_i;
   assign err_o       = 1'b0;
`endif

endmodule
